// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the systolic GF array command sequencer:
// command encodings, array op codes, gauss_op codes, FSM states and drain length.
package array_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_LOAD     = 3'd1,
        CMD_LOAD_KEY = 3'd2,
        CMD_EVAL     = 3'd3,
        CMD_MUL_RAND = 3'd4,
        CMD_SET_RAND = 3'd5,
        CMD_GAUSS    = 3'd6,
        CMD_SHIFT_B  = 3'd7
    } cmd_e;

    localparam logic [3:0] OP_IDLE     = 4'd0;
    localparam logic [3:0] OP_LOAD     = 4'd8;
    localparam logic [3:0] OP_LOAD_KEY = 4'd3;
    localparam logic [3:0] OP_EVAL     = 4'd4;
    localparam logic [3:0] OP_MUL_RAND = 4'd6;
    localparam logic [3:0] OP_SET_RAND = 4'd7;
    localparam logic [3:0] OP_GAUSS    = 4'd1;
    localparam logic [3:0] OP_SHIFT_B  = 4'd5;

    localparam logic [1:0] GOP_NONE = 2'b00;
    localparam logic [1:0] GOP_ELIM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Cycles for the last beat to ripple out of a rows x cols systolic array.
    function automatic int drain_cyc(input int rows, input int cols);
        return rows + cols;
    endfunction

    function automatic logic [3:0] op_code(input cmd_e cmd);
        case (cmd)
            CMD_LOAD:     return OP_LOAD;
            CMD_LOAD_KEY: return OP_LOAD_KEY;
            CMD_EVAL:     return OP_EVAL;
            CMD_MUL_RAND: return OP_MUL_RAND;
            CMD_SET_RAND: return OP_SET_RAND;
            CMD_GAUSS:    return OP_GAUSS;
            CMD_SHIFT_B:  return OP_SHIFT_B;
            default:      return OP_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] gauss_code(input cmd_e cmd);
        case (cmd)
            CMD_EVAL, CMD_GAUSS: return GOP_ELIM;
            default:             return GOP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/array_ctrl_cnt.sv
// Loadable down-counter with decrement enable and zero flag; saturates at zero.
module array_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/array_op_sequencer.sv
// Expands one high-level command into the per-beat op/start/finish/gauss_op stream
// for the systolic array. Define SRC_STALL_EN to gate beats on src_valid.
//
// state    | meaning
// ST_IDLE  | ready for a command
// ST_ISSUE | issuing beats of the current pass
// ST_DRAIN | waiting for the array pipeline to empty
// ST_DONE  | one-cycle completion pulse
module array_op_sequencer
    import array_ctrl_pkg::*;
#(
    parameter int OP_CODE_LEN  = 4,
    parameter int NUM_PROC_ROW = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int LEN_W        = 8,
    localparam int PIDX_W      = (NUM_PROC_COL > 1) ? $clog2(NUM_PROC_COL) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic [OP_CODE_LEN-1:0] op_out,
    output logic                   start_out,
    output logic                   finish_out,
    output logic [1:0]             gauss_op_out,
    output logic [PIDX_W-1:0]      pivot_idx,
    output logic                   pivot_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int DRAIN_CYC = drain_cyc(NUM_PROC_ROW, NUM_PROC_COL);
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    state_e             state_q, state_d;
    cmd_e               op_q;
    logic [LEN_W-1:0]   len_q;
    logic [PIDX_W-1:0]  pass_q;

    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beat_load_val;
    logic               beat_load;
    logic               beat_zero_unused;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               drain_zero;

    logic beat_en, fire, first_beat, last_beat;
    logic accept, drain_exp, more_pass;

`ifdef SRC_STALL_EN
    assign beat_en = src_valid;
`else
    logic src_valid_unused;
    assign src_valid_unused = src_valid;
    assign beat_en          = 1'b1;
`endif

    assign accept     = (state_q == ST_IDLE) && cmd_valid;
    assign fire       = (state_q == ST_ISSUE) && beat_en;
    assign first_beat = fire && (beat_cnt == len_q);
    assign last_beat  = fire && (beat_cnt == LEN_W'(1));
    assign drain_exp  = (state_q == ST_DRAIN) && drain_zero;
    assign more_pass  = (op_q == CMD_GAUSS) && (pass_q < PIDX_W'(NUM_PROC_COL - 1));

    assign beat_load     = accept || (drain_exp && more_pass);
    assign beat_load_val = accept ? cmd_len : len_q;

    array_ctrl_cnt #(.W(LEN_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load),
        .load_val (beat_load_val),
        .dec      (fire),
        .count    (beat_cnt),
        .zero     (beat_zero_unused)
    );

    // Loaded one short so the zero flag marks the final drain cycle.
    array_ctrl_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (last_beat),
        .load_val (DRAIN_W'(DRAIN_CYC - 1)),
        .dec      (state_q == ST_DRAIN),
        .count    (drain_cnt),
        .zero     (drain_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= CMD_NOP;
            len_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_e'(cmd_op);
                len_q  <= cmd_len;
                pass_q <= '0;
            end else if (drain_exp && more_pass) begin
                pass_q <= pass_q + PIDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_e'(cmd_op) == CMD_NOP) || (cmd_len == '0)) state_d = ST_DONE;
                    else                                                 state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_zero) state_d = more_pass ? ST_ISSUE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_out       = '0;
        start_out    = 1'b0;
        finish_out   = 1'b0;
        gauss_op_out = GOP_NONE;
        if (fire) begin
            op_out       = OP_CODE_LEN'(op_code(op_q));
            start_out    = first_beat;
            finish_out   = last_beat;
            gauss_op_out = gauss_code(op_q);
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign src_ready   = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign pivot_valid = (op_q == CMD_GAUSS) && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign pivot_idx   = pivot_valid ? pass_q : '0;

endmodule
